// File: rtl/half_vector_lane_streamer.sv
// Double-buffer-free vector staging: collects LENGTH element pairs one per cycle,
// then replays them as BEATS contiguous MULTS-lane beats for a lane-parallel consumer.
module half_vector_lane_streamer #(
  parameter int BITS   = 16,
  parameter int LENGTH = 10,
  parameter int MULTS  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [BITS-1:0]             wr_a,
  input  logic [BITS-1:0]             wr_b,
  input  logic                        start,
  output logic                        full,
  output logic                        out_valid,
  output logic [MULTS-1:0][BITS-1:0]  vector_a,
  output logic [MULTS-1:0][BITS-1:0]  vector_b,
  output logic                        last
);

  localparam int BEATS  = LENGTH / MULTS;
  localparam int CNT_W  = $clog2(LENGTH + 1);
  localparam int IDX_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FULL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t                     state_r, state_nxt;
  logic [CNT_W-1:0]           wr_cnt_r, wr_cnt_nxt;
  logic [BEAT_W-1:0]          beat_cnt_r, beat_cnt_nxt, beat_sel_s;
  logic [BITS-1:0]            mem_a_r [LENGTH];
  logic [BITS-1:0]            mem_b_r [LENGTH];
  logic                       wr_fire_s, out_valid_nxt, last_nxt, full_nxt;
  logic [IDX_W-1:0]           base_s;
  logic [MULTS-1:0][BITS-1:0] lanes_a_s, lanes_b_s;

  assign wr_ready  = (state_r == ST_LOAD) && !rst;
  assign wr_fire_s = wr_valid && wr_ready;

  // Next-state decode; beat_cnt always names the beat currently on the output registers.
  always_comb begin
    state_nxt     = state_r;
    wr_cnt_nxt    = wr_cnt_r;
    beat_cnt_nxt  = beat_cnt_r;
    beat_sel_s    = '0;
    out_valid_nxt = 1'b0;
    last_nxt      = 1'b0;
    full_nxt      = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (wr_fire_s) begin
          wr_cnt_nxt = wr_cnt_r + CNT_W'(1);
          if (wr_cnt_r == CNT_W'(LENGTH - 1)) begin
            state_nxt = ST_FULL;
            full_nxt  = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
          end
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_FULL: begin
        if (start) begin
          // Beat 0 is loaded on the start edge so the stream begins the next cycle.
          state_nxt     = ST_STREAM;
          beat_cnt_nxt  = '0;
          beat_sel_s    = '0;
          out_valid_nxt = 1'b1;
          last_nxt      = (BEATS == 1);
        end else begin
          full_nxt = 1'b1;
        end
      end
      ST_STREAM: begin
        if (beat_cnt_r == BEAT_W'(BEATS - 1)) begin
          state_nxt    = ST_LOAD;
          wr_cnt_nxt   = '0;
          beat_cnt_nxt = '0;
        end else begin
          beat_cnt_nxt  = beat_cnt_r + BEAT_W'(1);
          beat_sel_s    = beat_cnt_r + BEAT_W'(1);
          out_valid_nxt = 1'b1;
          last_nxt      = ((beat_cnt_r + BEAT_W'(1)) == BEAT_W'(BEATS - 1));
        end
      end
      default: begin
        state_nxt  = ST_LOAD;
        wr_cnt_nxt = '0;
      end
    endcase
  end

  // Lane gather for the upcoming beat; idle bus is forced to zero.
  always_comb begin
    base_s    = IDX_W'(int'(beat_sel_s) * MULTS);
    lanes_a_s = '0;
    lanes_b_s = '0;
    if (out_valid_nxt) begin
      for (int g = 0; g < MULTS; g++) begin
        lanes_a_s[g] = mem_a_r[base_s + IDX_W'(g)];
        lanes_b_s[g] = mem_b_r[base_s + IDX_W'(g)];
      end
    end else begin
      lanes_a_s = '0;
      lanes_b_s = '0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_LOAD;
      wr_cnt_r   <= '0;
      beat_cnt_r <= '0;
      out_valid  <= 1'b0;
      last       <= 1'b0;
      full       <= 1'b0;
      vector_a   <= '0;
      vector_b   <= '0;
    end else begin
      state_r    <= state_nxt;
      wr_cnt_r   <= wr_cnt_nxt;
      beat_cnt_r <= beat_cnt_nxt;
      out_valid  <= out_valid_nxt;
      last       <= last_nxt;
      full       <= full_nxt;
      vector_a   <= lanes_a_s;
      vector_b   <= lanes_b_s;
    end
  end

  // Element storage keeps stale data across loads; only accepted writes update it.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_a_r[IDX_W'(wr_cnt_r)] <= wr_a;
      mem_b_r[IDX_W'(wr_cnt_r)] <= wr_b;
    end
  end

endmodule

// File: doc/half_vector_lane_streamer.md
# half_vector_lane_streamer

Buffers one pair of half-precision vectors written one element per cycle, then streams them out as MULTS-lane beats with a valid strobe. It drives the lane-parallel `vector_a`/`vector_b`/`in_valid` input of the half-precision dot-product unit. The stream is exactly LENGTH/MULTS contiguous valid beats, so the downstream per-lane multiply-accumulators see one complete vector per start.

## Interface
- BITS, 16, element width (IEEE half, treated as opaque bits)
- LENGTH, 10, elements per vector; must be a multiple of MULTS
- MULTS, 2, lanes per output beat; BEATS = LENGTH/MULTS
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  element pair present on wr_a/wr_b
- wr_ready  out  1  buffer accepting writes (LOAD state)
- wr_a  in  BITS  element of vector A
- wr_b  in  BITS  element of vector B
- start  in  1  begin streaming; honoured only in FULL
- full  out  1  buffer holds LENGTH elements, awaiting start
- out_valid  out  1  beat valid; drives consumer in_valid
- vector_a  out  BITS x MULTS  lane array, A elements
- vector_b  out  BITS x MULTS  lane array, B elements
- last  out  1  high with the final beat of a stream

## Operation
- Storage: two LENGTH-entry arrays (A, B), a write counter wr_cnt [0..LENGTH], a beat counter beat_cnt [0..BEATS-1].
- State machine:
  - LOAD: wr_ready=1. A write occurs when wr_valid&wr_ready. The write stores wr_a/wr_b at index wr_cnt and increments wr_cnt. The write that makes wr_cnt==LENGTH moves to FULL.
  - FULL: wr_ready=0, full=1. wr_valid is ignored (no store). start=1 moves to STREAM and clears beat_cnt.
  - STREAM: one beat per cycle, no stalls. Beat k presents element k*MULTS+g on lane g of both arrays. After beat BEATS-1 the block returns to LOAD with wr_cnt=0.
- start outside FULL is ignored; it is not remembered.
- Writes are never accepted in FULL or STREAM. A producer holding wr_valid high simply waits for wr_ready.
- Buffer contents are not cleared on return to LOAD; they are overwritten by new writes.
- Lane outputs are zero whenever out_valid=0, so an idle bus reads all-zero.

## Timing
- Reset (rst high at an edge), effective the following cycle:
  - state=LOAD, wr_cnt=0, beat_cnt=0
  - out_valid=0, last=0, full=0, vector_a/vector_b=0
  - wr_ready=1 from the first cycle after rst deasserts; wr_ready=0 while rst is high.
- Outputs out_valid, last, vector_a, vector_b and full are registered. wr_ready is decoded from the state.
- Latency:
  - The final write, accepted at edge t, gives full=1 in cycle t+1.
  - start sampled high in FULL at edge s gives out_valid=1 in cycles s+1 .. s+BEATS.
  - last=1 in cycle s+BEATS only.
  - wr_ready=1 again in cycle s+BEATS+1.
- Minimum period between stream starts is LENGTH write cycles + 1 start cycle + BEATS cycles.
- Boundary conditions:
  - Reset mid-LOAD discards partial writes.
  - Reset mid-STREAM aborts the stream; out_valid=0 the next cycle and no last pulse is issued.
  - start and wr_valid high together in LOAD: the write proceeds and start is ignored.
  - start held high across FULL→STREAM→LOAD is not re-honoured until the next FULL.
  - MULTS==LENGTH: BEATS=1, and last is asserted together with the single out_valid beat.

## Test plan
- Reset check: assert rst for 2 cycles → out_valid=0, full=0, vector_a[0..1]=0, wr_ready=0 during reset, then 1.
- Basic stream (LENGTH=10, MULTS=2):
  - Stimulus: write A=0x0001..0x000A and B=0x0101..0x010A, then pulse start.
  - Required: 5 contiguous beats.
  - Beat 0: A lanes {0x0001,0x0002}, B lanes {0x0101,0x0102}.
  - Beat 4: A lanes {0x0009,0x000A}, B lanes {0x0109,0x010A}, last=1.
- Gapped writes and stray control:
  - Stimulus: 10 writes with wr_valid toggled every other cycle; start pulsed during LOAD.
  - Required: no stream starts; full=1 exactly one cycle after the 10th accepted write.
- Backpressure: hold wr_valid high with new data after full → wr_ready=0, buffer unchanged, and the streamed data matches the first 10 writes.
- End-to-end:
  - Stimulus: connect to the dot-product unit; A=all 0x3C00 (1.0), B=all 0x4000 (2.0).
  - Required: dot-product output = 0x4D00 (20.0).
  - Then stream a second vector pair back-to-back → second result correct.
- Abort: assert rst during beat 2 → out_valid low the next cycle, no last pulse, wr_ready=1 after release, and a fresh load/stream of 10 elements succeeds.
